// File: rtl/cfu_pkg.sv
// Shared definitions for the Cfu command path: operand widths, the
// command payload record and the funct7 field extractor.
package cfu_pkg;

   localparam int FUNC_W     = 10;
   localparam int DATA_W     = 32;
   localparam int FUNCT7_LSB = 3;
   localparam int FUNCT7_W   = 7;

   // One custom-instruction command exactly as issued by the CPU.
   typedef struct packed {
      logic [FUNC_W-1:0] function_id;
      logic [DATA_W-1:0] inputs_0;
      logic [DATA_W-1:0] inputs_1;
   } cfu_cmd_t;

   // funct7 lives in the upper bits of function_id; funct3 in the lower three.
   function automatic logic [FUNCT7_W-1:0] funct7_of(input logic [FUNC_W-1:0] function_id);
      return function_id[FUNCT7_LSB +: FUNCT7_W];
   endfunction

endpackage

// File: rtl/cfu_fifo_ptr.sv
// Read/write pointer, occupancy and full/empty tracking for a power-of-two
// FIFO. Kept storage-agnostic so a response queue can reuse it.
module cfu_fifo_ptr #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_flush,
   input  logic          i_push_req,
   input  logic          i_pop_req,
   output logic          o_push,
   output logic          o_pop,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW-1:0] o_wr_addr,
   output logic [AW-1:0] o_rd_addr,
   output logic [PW-1:0] o_count
);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   // The extra MSB separates "same slot, one lap ahead" (full) from
   // "same slot, same lap" (empty); wrap is plain modulo 2*DEPTH.
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   // Handshakes qualified only by registered state; flush cancels both.
   assign w_push = i_push_req && !w_full  && !i_flush;
   assign w_pop  = i_pop_req  && !w_empty && !i_flush;

   // Pointer and occupancy registers; flush outranks push and pop.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values and simulation order cannot change the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + PW'(1);
            2'b01:   r_count <= r_count - PW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_push    = w_push;
   assign o_pop     = w_pop;
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_wr_addr = r_wr_ptr[AW-1:0];
   assign o_rd_addr = r_rd_ptr[AW-1:0];
   assign o_count   = r_count;

endmodule

// File: rtl/cfu_cmd_fifo.sv
// Command queue between the CPU and the Cfu. Buffers custom-instruction
// commands so the CPU can keep issuing while the Cfu holds a response.
// First-word-fall-through head; ready toward the CPU depends only on
// registered occupancy, never on m_cmd_ready.
module cfu_cmd_fifo #(
   parameter  int DEPTH  = 4,
   parameter  int FUNC_W = cfu_pkg::FUNC_W,
   parameter  int DATA_W = cfu_pkg::DATA_W,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              s_cmd_valid,
   output logic              s_cmd_ready,
   input  logic [FUNC_W-1:0] s_cmd_payload_function_id,
   input  logic [DATA_W-1:0] s_cmd_payload_inputs_0,
   input  logic [DATA_W-1:0] s_cmd_payload_inputs_1,
   output logic              m_cmd_valid,
   input  logic              m_cmd_ready,
   output logic [FUNC_W-1:0] m_cmd_payload_function_id,
   output logic [DATA_W-1:0] m_cmd_payload_inputs_0,
   output logic [DATA_W-1:0] m_cmd_payload_inputs_1,
   output logic [CW-1:0]     count
);

   import cfu_pkg::cfu_cmd_t;

   // Storage is the shared command record, so widths must match the package.
   if (FUNC_W != cfu_pkg::FUNC_W || DATA_W != cfu_pkg::DATA_W) begin : g_width_check
      $error("cfu_cmd_fifo: FUNC_W/DATA_W must match cfu_pkg");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("cfu_cmd_fifo: DEPTH must be a power of two, at least 2");
   end

   cfu_cmd_t        r_mem [DEPTH];
   cfu_cmd_t        w_in_cmd;
   cfu_cmd_t        w_head;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [AW-1:0]   w_wr_addr;
   logic [AW-1:0]   w_rd_addr;
   logic [CW-1:0]   w_count;

   assign w_in_cmd = '{function_id: s_cmd_payload_function_id,
                       inputs_0:    s_cmd_payload_inputs_0,
                       inputs_1:    s_cmd_payload_inputs_1};

   cfu_fifo_ptr #(
      .DEPTH (DEPTH)
   ) u_ptr (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_flush    (flush),
      .i_push_req (s_cmd_valid),
      .i_pop_req  (m_cmd_ready),
      .o_push     (w_push),
      .o_pop      (w_pop),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_wr_addr  (w_wr_addr),
      .o_rd_addr  (w_rd_addr),
      .o_count    (w_count)
   );

   // Write the accepted command into the tail slot.
   // NOTE: the array has no reset; unread slots are never visible because the
   // head is masked while empty, and resetting it would only cost flops.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_wr_addr] <= w_in_cmd;
   end

   // Present the head slot, forced to zero while the queue is empty.
   // NOTE: the default assignment first keeps this purely combinational; a
   // path that leaves w_head unassigned would infer a latch.
   always_comb begin
      w_head = '0;
      if (!w_empty) w_head = r_mem[w_rd_addr];
   end

   assign s_cmd_ready               = !w_full;
   assign m_cmd_valid               = !w_empty;
   assign m_cmd_payload_function_id = w_head.function_id;
   assign m_cmd_payload_inputs_0    = w_head.inputs_0;
   assign m_cmd_payload_inputs_1    = w_head.inputs_1;
   assign count                     = w_count;

endmodule

// File: tb/tb_cfu_cmd_fifo.sv
// Self-checking bench for cfu_cmd_fifo: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_cfu_cmd_fifo;

   localparam int DEPTH  = 4;
   localparam int FUNC_W = 10;
   localparam int DATA_W = 32;
   localparam int CW     = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [FUNC_W-1:0] fid;
      logic [DATA_W-1:0] in0;
      logic [DATA_W-1:0] in1;
   } cmd_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              s_cmd_valid;
   logic              s_cmd_ready;
   logic [FUNC_W-1:0] s_fid;
   logic [DATA_W-1:0] s_in0;
   logic [DATA_W-1:0] s_in1;
   logic              m_cmd_valid;
   logic              m_cmd_ready;
   logic [FUNC_W-1:0] m_fid;
   logic [DATA_W-1:0] m_in0;
   logic [DATA_W-1:0] m_in1;
   logic [CW-1:0]     count;

   int   n_tests = 0;
   int   n_fail  = 0;
   cmd_t model_q[$];

   always #5 clk = ~clk;

   cfu_cmd_fifo #(
      .DEPTH  (DEPTH),
      .FUNC_W (FUNC_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .flush                     (flush),
      .s_cmd_valid               (s_cmd_valid),
      .s_cmd_ready               (s_cmd_ready),
      .s_cmd_payload_function_id (s_fid),
      .s_cmd_payload_inputs_0    (s_in0),
      .s_cmd_payload_inputs_1    (s_in1),
      .m_cmd_valid               (m_cmd_valid),
      .m_cmd_ready               (m_cmd_ready),
      .m_cmd_payload_function_id (m_fid),
      .m_cmd_payload_inputs_0    (m_in0),
      .m_cmd_payload_inputs_1    (m_in1),
      .count                     (count)
   );

   function automatic cmd_t obs_head();
      return cmd_t'({m_fid, m_in0, m_in1});
   endfunction

   function automatic cmd_t exp_head();
      if (model_q.size() == 0) return '0;
      return model_q[0];
   endfunction

   function automatic cmd_t mk(input int unsigned fid, input int unsigned in0, input int unsigned in1);
      cmd_t c;
      c.fid = FUNC_W'(fid);
      c.in0 = in0;
      c.in1 = in1;
      return c;
   endfunction

   task automatic set_cmd(input cmd_t c);
      s_fid = c.fid;
      s_in0 = c.in0;
      s_in1 = c.in1;
   endtask

   // Advance one clock: the model applies the queue rules to the pre-edge
   // occupancy and inputs, then inputs may change 1 ns after the edge.
   task automatic clk_edge();
      int sz;
      bit do_push;
      bit do_pop;
      sz = model_q.size();
      if (flush) begin
         model_q.delete();
      end else begin
         do_pop  = m_cmd_ready && (sz > 0);
         do_push = s_cmd_valid && (sz < DEPTH);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(cmd_t'({s_fid, s_in0, s_in1}));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_n_stalled(input int n, input int base);
      m_cmd_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         set_cmd(mk(i + 1, base + i, 32'hC0DE_0000 + i));
         s_cmd_valid = 1'b1;
         clk_edge();
      end
      s_cmd_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      m_cmd_ready = 1'b1;
      s_cmd_valid = 1'b0;
      for (int cyc = 0; cyc < 3 * DEPTH && model_q.size() > 0; cyc++) begin
         n_tests++;
         if (m_cmd_valid !== 1'b1 || obs_head() !== exp_head()) begin
            n_fail++;
            $display("FAIL %s_drain: valid=%0b head=%h required valid=1 head=%h",
                     tag, m_cmd_valid, obs_head(), exp_head());
         end
         clk_edge();
      end
      m_cmd_ready = 1'b0;
      n_tests++;
      if (model_q.size() != 0 || count !== CW'(0) || m_cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain_empty: count=%0d valid=%0b model=%0d required 0/0/0",
                  tag, count, m_cmd_valid, model_q.size());
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (count !== CW'(0) || m_cmd_valid !== 1'b0 || s_cmd_ready !== 1'b1 || obs_head() !== cmd_t'(0)) begin
         n_fail++;
         $display("FAIL reset_initial: count=%0d valid=%0b ready=%0b head=%h required 0/0/1/0",
                  count, m_cmd_valid, s_cmd_ready, obs_head());
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      push_n_stalled(3, 32'h10);
      n_tests++;
      if (count !== CW'(3)) begin
         n_fail++;
         $display("FAIL reset_prefill: count=%0d required 3", count);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (count !== CW'(0) || m_cmd_valid !== 1'b0 || s_cmd_ready !== 1'b1 || obs_head() !== cmd_t'(0)) begin
         n_fail++;
         $display("FAIL reset_async: count=%0d valid=%0b ready=%0b head=%h required 0/0/1/0",
                  count, m_cmd_valid, s_cmd_ready, obs_head());
      end
      model_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_pass_through();
      cmd_t c;
      c = mk(10'h008, 32'h0102_0304, 32'hA0B0_C0D0);
      set_cmd(c);
      s_cmd_valid = 1'b1;
      m_cmd_ready = 1'b1;
      n_tests++;
      if (m_cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pass_no_bypass: valid=%0b required 0", m_cmd_valid);
      end
      clk_edge();
      s_cmd_valid = 1'b0;
      n_tests++;
      if (m_cmd_valid !== 1'b1 || obs_head() !== c || count !== CW'(1)) begin
         n_fail++;
         $display("FAIL pass_out: valid=%0b head=%h count=%0d required 1/%h/1",
                  m_cmd_valid, obs_head(), count, c);
      end
      clk_edge();
      m_cmd_ready = 1'b0;
      n_tests++;
      if (m_cmd_valid !== 1'b0 || count !== CW'(0)) begin
         n_fail++;
         $display("FAIL pass_popped: valid=%0b count=%0d required 0/0", m_cmd_valid, count);
      end
   endtask

   task automatic test_fill_wrap();
      int next_in;
      int exp_seq;
      push_n_stalled(4, 1);
      n_tests++;
      if (s_cmd_ready !== 1'b0 || count !== CW'(4)) begin
         n_fail++;
         $display("FAIL fill_full: ready=%0b count=%0d required 0/4", s_cmd_ready, count);
      end
      next_in = 5;
      exp_seq = 1;
      m_cmd_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && exp_seq <= 8; cyc++) begin
         if (next_in <= 8) begin
            set_cmd(mk(next_in, next_in, 32'hC0DE_0000 + next_in));
            s_cmd_valid = 1'b1;
         end else begin
            s_cmd_valid = 1'b0;
         end
         if (m_cmd_valid === 1'b1) begin
            n_tests++;
            if (m_in0 !== DATA_W'(exp_seq)) begin
               n_fail++;
               $display("FAIL wrap_order: in0=%0d required %0d", m_in0, exp_seq);
            end
            exp_seq++;
         end
         if (s_cmd_valid && s_cmd_ready === 1'b1) next_in++;
         clk_edge();
      end
      s_cmd_valid = 1'b0;
      m_cmd_ready = 1'b0;
      n_tests++;
      if (exp_seq != 9 || count !== CW'(0)) begin
         n_fail++;
         $display("FAIL wrap_done: outputs=%0d count=%0d required 8/0", exp_seq - 1, count);
      end
   endtask

   task automatic test_full_simultaneous();
      push_n_stalled(4, 32'h101);
      set_cmd(mk(10'h3FF, 32'h55AA_55AA, 32'h1234_5678));
      s_cmd_valid = 1'b1;
      m_cmd_ready = 1'b1;
      n_tests++;
      if (s_cmd_ready !== 1'b0 || count !== CW'(4)) begin
         n_fail++;
         $display("FAIL fullsim_pre: ready=%0b count=%0d required 0/4", s_cmd_ready, count);
      end
      clk_edge();
      m_cmd_ready = 1'b0;
      n_tests++;
      if (count !== CW'(3) || s_cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fullsim_pop_only: count=%0d ready=%0b required 3/1", count, s_cmd_ready);
      end
      clk_edge();
      s_cmd_valid = 1'b0;
      n_tests++;
      if (count !== CW'(4)) begin
         n_fail++;
         $display("FAIL fullsim_accept: count=%0d required 4", count);
      end
      drain("fullsim");
   endtask

   task automatic test_backpressure();
      cmd_t c;
      c = mk(10'h155, 32'hDEAD_BEEF, 32'hFEED_F00D);
      set_cmd(c);
      s_cmd_valid = 1'b1;
      m_cmd_ready = 1'b0;
      clk_edge();
      s_cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (m_cmd_valid !== 1'b1 || obs_head() !== c || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL backpressure_cycle%0d: valid=%0b head=%h count=%0d required 1/%h/1",
                     i, m_cmd_valid, obs_head(), count, c);
         end
         clk_edge();
      end
      drain("backpressure");
   endtask

   task automatic test_flush();
      push_n_stalled(2, 32'h200);
      n_tests++;
      if (count !== CW'(2)) begin
         n_fail++;
         $display("FAIL flush_prefill: count=%0d required 2", count);
      end
      set_cmd(mk(10'h2AA, 32'hBADC_0FFE, 32'h0BAD_F00D));
      s_cmd_valid = 1'b1;
      m_cmd_ready = 1'b1;
      flush       = 1'b1;
      clk_edge();
      flush       = 1'b0;
      s_cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (count !== CW'(0) || m_cmd_valid !== 1'b0 || m_in0 === 32'hBADC_0FFE) begin
            n_fail++;
            $display("FAIL flush_cycle%0d: count=%0d valid=%0b in0=%h required 0/0/not badc0ffe",
                     i, count, m_cmd_valid, m_in0);
         end
         clk_edge();
      end
      m_cmd_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         s_cmd_valid = ($urandom_range(0, 3) != 0);
         m_cmd_ready = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 40) == 0);
         set_cmd(mk($urandom, $urandom, $urandom));
         n_tests++;
         if ({m_cmd_valid, s_cmd_ready, count, obs_head()} !==
             {model_q.size() != 0, model_q.size() < DEPTH, CW'(model_q.size()), exp_head()}) begin
            n_fail++;
            $display("FAIL random_cyc%0d: valid=%0b ready=%0b count=%0d head=%h required %0b/%0b/%0d/%h",
                     cyc, m_cmd_valid, s_cmd_ready, count, obs_head(),
                     model_q.size() != 0, model_q.size() < DEPTH, model_q.size(), exp_head());
         end
         clk_edge();
      end
      flush       = 1'b0;
      s_cmd_valid = 1'b0;
      drain("random");
   endtask

   initial begin
      reset_n     = 1'b0;
      flush       = 1'b0;
      s_cmd_valid = 1'b0;
      m_cmd_ready = 1'b0;
      set_cmd('0);
      test_reset();
      test_pass_through();
      test_fill_wrap();
      test_full_simultaneous();
      test_backpressure();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cfu_cmd_fifo.md
Name: cfu_cmd_fifo

Overview:
- Command queue in front of the Cfu top: buffers CPU-issued custom-instruction commands (function_id plus two 32-bit operands) and replays them to the Cfu.
- Lets the CPU keep issuing while the Cfu is busy holding a response (Cfu cmd_ready low).
- Valid/ready on both sides; registered, first-word-fall-through output; no combinational path from m_cmd_ready to s_cmd_ready.

Parameters:
DEPTH, 4, number of queued commands; power of two, at least 2
FUNC_W, 10, function_id width; funct7 = function_id[9:3]
DATA_W, 32, operand width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all queued entries
s_cmd_valid  input  1  CPU command valid
s_cmd_ready  output  1  queue can accept a command
s_cmd_payload_function_id  input  FUNC_W  CPU function id
s_cmd_payload_inputs_0  input  DATA_W  operand 0
s_cmd_payload_inputs_1  input  DATA_W  operand 1
m_cmd_valid  output  1  head entry valid toward the Cfu
m_cmd_ready  input  1  Cfu accepts head entry
m_cmd_payload_function_id  output  FUNC_W  head function id
m_cmd_payload_inputs_0  output  DATA_W  head operand 0
m_cmd_payload_inputs_1  output  DATA_W  head operand 1
count  output  $clog2(DEPTH)+1  current occupancy, 0 to DEPTH

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; m_cmd_valid=0; s_cmd_ready=1.
  - Payload outputs are 0.
  - Storage contents are don't-care.
  - Reset mid-transfer drops every queued entry, with no partial output.
- Pointers are $clog2(DEPTH)+1 bits wide.
  - Full: MSBs differ and the lower bits are equal.
  - Empty: pointers are equal.
  - Wrap-around is natural modulo 2*DEPTH.
- Push happens when s_cmd_valid && s_cmd_ready.
  - s_cmd_ready = !full, registered-state only.
  - A push while full is impossible, so no overflow can occur.
- Pop happens when m_cmd_valid && m_cmd_ready.
  - m_cmd_valid = !empty.
  - Payload outputs present the rd_ptr entry (FWFT).
  - Payload is held stable while m_cmd_valid && !m_cmd_ready.
- Latency:
  - A push into an empty queue appears at m_cmd_valid on the next cycle. There is no same-cycle bypass.
  - Minimum in-to-out latency is 1 cycle.
- Simultaneous push and pop:
  - Not full and not empty: both occur and count is unchanged.
  - Full: only the pop occurs; s_cmd_ready was 0.
  - Empty: only the push occurs; m_cmd_valid was 0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- flush:
  - At the next edge, pointers and count go to 0 and any same-cycle push is discarded.
  - flush has priority over push and pop.
  - Intended use: a CPU pipeline kill.
- The payload is never modified; the block is transparent to funct7 semantics.
- Order is strict FIFO.
- The Cfu's own cmd_ready = ~rsp_valid drives m_cmd_ready directly, with no extra logic.

Decomposition:
- Shared package cfu_pkg holds:
  - FUNC_W, DATA_W, FUNCT7_LSB=3, FUNCT7_W=7;
  - a packed struct cfu_cmd_t {function_id, inputs_0, inputs_1};
  - a function funct7_of(function_id).
- Storage is an array of cfu_cmd_t.
- One natural sub-module is cfu_fifo_ptr: pointer/full/empty/count logic, reusable for a future response queue.

Test Plan:
- Reset then idle: assert reset_n=0 mid-run with 3 entries queued -> count=0, m_cmd_valid=0, s_cmd_ready=1 immediately, without waiting for a clock edge.
- Single pass-through:
  - push {fid=0x008, in0=0x01020304, in1=0xA0B0C0D0} with m_cmd_ready=1;
  - -> m_cmd_valid high exactly 1 cycle later with identical payload; count goes 1 then 0.
- Fill and wrap:
  - hold m_cmd_ready=0 and push 4 commands (in0=1,2,3,4) -> s_cmd_ready=0, count=4;
  - release and push 4 more (in0=5..8) -> output order 1..8, with pointers wrapping once.
- Full simultaneous:
  - at count=4, assert s_cmd_valid and m_cmd_ready;
  - -> only the pop occurs (count=3), and the offered command is accepted on the following cycle.
- Backpressure stability:
  - head in0=0xDEADBEEF with m_cmd_ready low for 5 cycles;
  - -> payload and m_cmd_valid constant over all 5 cycles, no pop.
- Flush priority:
  - count=2, assert flush together with a push and a pop;
  - -> next cycle count=0, m_cmd_valid=0, and the pushed entry never appears at the output.
